// File: rtl/lpm_cnt_pkg.sv
// Shared types and helpers for the modulus counter family.
// LPM widths are limited to CNT_MAX_W bits by the modulus helper.
package lpm_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int CNT_MAX_W = 64;

  // A zero modulus selects the full 2^width range.
  function automatic logic [CNT_MAX_W:0] eff_modulus(input logic [CNT_MAX_W-1:0] mod_in,
                                                     input int width);
    if (mod_in == '0) begin
      eff_modulus = (CNT_MAX_W+1)'(1) << width;
    end else begin
      eff_modulus = {1'b0, mod_in};
    end
  endfunction

endpackage

// File: rtl/lpm_cnt_next.sv
// Combinational next-count and terminal-count for a modulus-M counter.
// Out-of-range inputs map back into [0, M-1] on the next count.
module lpm_cnt_next #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_q,
  input  logic [W:0]   i_mod,
  input  logic         i_dir,
  output logic [W-1:0] o_nxt,
  output logic         o_tc
);
  import lpm_cnt_pkg::*;

  logic [W:0] w_q_ext;
  logic [W:0] w_last;

  assign w_q_ext = {1'b0, i_q};
  assign w_last  = i_mod - (W+1)'(1);

  always_comb begin
    o_tc  = 1'b0;
    o_nxt = i_q;
    if (i_dir == DIR_UP) begin
      o_tc  = (w_q_ext == w_last);
      o_nxt = (w_q_ext >= w_last) ? '0 : i_q + W'(1);
    end else begin
      o_tc  = (i_q == '0);
      o_nxt = ((i_q == '0) || (w_q_ext >= i_mod)) ? w_last[W-1:0] : i_q - W'(1);
    end
  end

endmodule

// File: rtl/lpm_counter_mod.sv
// Up/down modulus counter with cascade carry and one-shot run/done FSM; q updates one edge after inputs.
// Optional snapshot register (snap/q_snap) is built when LPM_CNT_SNAPSHOT_EN is defined.
module lpm_counter_mod #(
  parameter int    LPM_WIDTH     = 8,
  parameter string LPM_DIRECTION = "UNUSED",
  parameter int    LPM_SVALUE    = 0
) (
  input  logic                 clock,
  input  logic                 sclr,
  input  logic                 sset,
  input  logic                 sload,
  input  logic [LPM_WIDTH-1:0] data,
  input  logic                 cnt_en,
  input  logic                 cin,
  input  logic                 updown,
  input  logic [LPM_WIDTH-1:0] modulus,
  input  logic                 oneshot,
  input  logic                 start,
`ifdef LPM_CNT_SNAPSHOT_EN
  input  logic                 snap,
  output logic [LPM_WIDTH-1:0] q_snap,
`endif
  output logic [LPM_WIDTH-1:0] q,
  output logic                 tc,
  output logic                 cout,
  output logic                 done,
  output logic                 busy
);
  import lpm_cnt_pkg::*;

  localparam logic [1:0] DIR_MODE = (LPM_DIRECTION == "UP")   ? 2'd1 :
                                    (LPM_DIRECTION == "DOWN") ? 2'd2 : 2'd0;
  localparam logic [LPM_WIDTH-1:0] SVAL = LPM_WIDTH'(LPM_SVALUE);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic [LPM_WIDTH-1:0] r_q;
  logic [LPM_WIDTH-1:0] w_q_nxt;
  logic [LPM_WIDTH-1:0] w_cnt_q;
  logic [LPM_WIDTH:0]   w_mod;
  logic                 w_dir;
  logic                 w_tc;
  logic                 w_cnt_ok;
  logic                 w_count;

  assign w_mod = (LPM_WIDTH+1)'(eff_modulus(CNT_MAX_W'(modulus), LPM_WIDTH));
  assign w_dir = (DIR_MODE == 2'd1) ? DIR_UP :
                 (DIR_MODE == 2'd2) ? DIR_DOWN : updown;

  lpm_cnt_next #(.W(LPM_WIDTH)) u_next (
    .i_q   (r_q),
    .i_mod (w_mod),
    .i_dir (w_dir),
    .o_nxt (w_cnt_q),
    .o_tc  (w_tc)
  );

  // Loads win over counting, so a load edge is never a counting edge.
  assign w_cnt_ok = cnt_en & cin & (~oneshot | (r_state == ST_RUN));
  assign w_count  = w_cnt_ok & ~sset & ~sload;

  always_comb begin
    w_q_nxt = r_q;
    if (sset) begin
      w_q_nxt = SVAL;
    end else if (sload) begin
      w_q_nxt = data;
    end else if (w_cnt_ok) begin
      w_q_nxt = w_cnt_q;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (!oneshot) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (w_count && w_tc) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      r_q     <= '0;
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef LPM_CNT_SNAPSHOT_EN
  logic [LPM_WIDTH-1:0] r_snap;

  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      r_snap <= '0;
    end else if (snap) begin
      r_snap <= r_q;
    end
  end

  assign q_snap = r_snap;
`endif

  assign q    = r_q;
  assign tc   = w_tc;
  assign cout = w_tc & w_cnt_ok;
  assign done = r_done;
  assign busy = (r_state == ST_RUN);

endmodule
